exu_div: RTL and testbench

EXU_DIV -- requirements
Module: exu_div

---
 rtl/exu_pkg.sv | 34 +++
 rtl/exu_div_core.sv | 55 +++++
 rtl/exu_div.sv | 143 ++++++++++++++
 tb/tb_exu_div.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/exu_pkg.sv
// Shared execution-unit definitions: datapath width, divider op codes and
// divider FSM state encodings, plus small op-decode helpers.
package exu_pkg;

   localparam int XLEN = 64;

   // Most negative signed XLEN value; dividing it by -1 overflows.
   localparam logic [XLEN-1:0] XLEN_MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

   typedef enum logic [1:0] {
      OP_DIV  = 2'b00,
      OP_DIVU = 2'b01,
      OP_REM  = 2'b10,
      OP_REMU = 2'b11
   } div_op_e;

   typedef enum logic [1:0] {
      ST_IDLE = 2'b00,
      ST_CALC = 2'b01,
      ST_FIX  = 2'b10,
      ST_DONE = 2'b11
   } div_state_e;

   // Signed ops treat both operands as two's complement.
   function automatic logic op_is_signed(div_op_e op);
      return (op == OP_DIV) || (op == OP_REM);
   endfunction

   // Remainder ops write back the remainder instead of the quotient.
   function automatic logic op_is_rem(div_op_e op);
      return (op == OP_REM) || (op == OP_REMU);
   endfunction

endpackage

// File: rtl/exu_div_core.sv
// Unsigned restoring divider datapath: holds the partial remainder and the
// quotient shift register, and performs one shift-subtract step per enable.
module exu_div_core
   import exu_pkg::*;
(
   input  logic            clk,
   input  logic            rst_clk,
   input  logic            load,
   input  logic            step,
   input  logic [XLEN-1:0] dividend,
   input  logic [XLEN-1:0] divisor,
   output logic [XLEN-1:0] quotient,
   output logic [XLEN-1:0] remainder
);

   logic [XLEN-1:0] rem_q;
   logic [XLEN-1:0] quo_q;
   logic [XLEN-1:0] dvs_q;
   logic [XLEN:0]   trial;
   logic [XLEN:0]   diff;

   // Trial subtraction: shift the next dividend bit into the partial remainder.
   // The top bit of diff set means the trial value is below the divisor.
   always_comb begin
      trial = {rem_q, quo_q[XLEN-1]};
      diff  = trial - {1'b0, dvs_q};
   end

   // Operand load on accept, then one restoring step per enabled cycle.
   always_ff @(posedge clk or negedge rst_clk) begin
      // NOTE: datapath registers are reset too, so the unit comes out of reset
      // in a fully known state; state updates use non-blocking assignments.
      if (!rst_clk) begin
         rem_q <= '0;
         quo_q <= '0;
         dvs_q <= '0;
      end else if (load) begin
         rem_q <= '0;
         quo_q <= dividend;
         dvs_q <= divisor;
      end else if (step) begin
         if (!diff[XLEN]) begin
            rem_q <= diff[XLEN-1:0];
            quo_q <= {quo_q[XLEN-2:0], 1'b1};
         end else begin
            rem_q <= trial[XLEN-1:0];
            quo_q <= {quo_q[XLEN-2:0], 1'b0};
         end
      end
   end

   assign quotient  = quo_q;
   assign remainder = rem_q;

endmodule

// File: rtl/exu_div.sv
// 64-bit integer divide unit: issue handshake, IDLE/CALC/FIX/DONE control,
// sign handling, divide-by-zero and overflow shortcuts, registered writeback.
module exu_div
   import exu_pkg::*;
#(
   parameter int PREG_W = 6
)(
   input  logic              clk,
   input  logic              rst_clk,
   input  logic              rtu_global_flush,
   input  logic              idu_div_sel,
   input  logic [1:0]        idu_div_op,
   input  logic [PREG_W-1:0] idu_div_preg,
   input  logic [XLEN-1:0]   idu_div_src0,
   input  logic [XLEN-1:0]   idu_div_src1,
   output logic              div_idu_ready,
   output logic              x_div_vld,
   output logic [PREG_W-1:0] x_div_preg,
   output logic [XLEN-1:0]   x_div_result
);

   div_state_e        state;
   logic [5:0]        cnt;
   div_op_e           op_q;
   logic [PREG_W-1:0] preg_q;
   logic              quo_neg;
   logic              rem_neg;

   div_op_e           issue_op;
   logic              issue_signed;
   logic              src0_neg;
   logic              src1_neg;
   logic              div_zero;
   logic              overflow;
   logic              accept;
   logic              core_load;
   logic              core_step;
   logic [XLEN-1:0]   abs0;
   logic [XLEN-1:0]   abs1;
   logic [XLEN-1:0]   special_res;
   logic [XLEN-1:0]   core_quo;
   logic [XLEN-1:0]   core_rem;
   logic [XLEN-1:0]   fixed_quo;
   logic [XLEN-1:0]   fixed_rem;

   // Issue decode: operand magnitudes, special-case detection, shortcut
   // results, and sign correction of the core outputs for the FIX step.
   always_comb begin
      // NOTE: every signal is assigned on every path so no latch is inferred.
      issue_op     = div_op_e'(idu_div_op);
      issue_signed = op_is_signed(issue_op);
      src0_neg     = issue_signed & idu_div_src0[XLEN-1];
      src1_neg     = issue_signed & idu_div_src1[XLEN-1];
      abs0         = src0_neg ? -idu_div_src0 : idu_div_src0;
      abs1         = src1_neg ? -idu_div_src1 : idu_div_src1;
      div_zero     = (idu_div_src1 == '0);
      overflow     = issue_signed && !div_zero &&
                     (idu_div_src0 == XLEN_MIN_NEG) && (idu_div_src1 == '1);
      accept       = (state == ST_IDLE) && idu_div_sel && !rtu_global_flush;
      core_load    = accept && !div_zero && !overflow;
      core_step    = (state == ST_CALC);
      if (div_zero) begin
         special_res = op_is_rem(issue_op) ? idu_div_src0 : '1;
      end else begin
         special_res = op_is_rem(issue_op) ? '0 : idu_div_src0;
      end
      fixed_quo = quo_neg ? -core_quo : core_quo;
      fixed_rem = rem_neg ? -core_rem : core_rem;
   end

   exu_div_core u_core (
      .clk       (clk),
      .rst_clk   (rst_clk),
      .load      (core_load),
      .step      (core_step),
      .dividend  (abs0),
      .divisor   (abs1),
      .quotient  (core_quo),
      .remainder (core_rem)
   );

   // Control FSM with registered ready and writeback outputs; flush wins.
   always_ff @(posedge clk or negedge rst_clk) begin
      if (!rst_clk) begin
         state         <= ST_IDLE;
         cnt           <= '0;
         op_q          <= OP_DIV;
         preg_q        <= '0;
         quo_neg       <= 1'b0;
         rem_neg       <= 1'b0;
         div_idu_ready <= 1'b1;
         x_div_vld     <= 1'b0;
         x_div_preg    <= '0;
         x_div_result  <= '0;
      end else if (rtu_global_flush) begin
         state         <= ST_IDLE;
         cnt           <= '0;
         div_idu_ready <= 1'b1;
         x_div_vld     <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (accept) begin
                  op_q          <= issue_op;
                  preg_q        <= idu_div_preg;
                  quo_neg       <= src0_neg ^ src1_neg;
                  rem_neg       <= src0_neg;
                  div_idu_ready <= 1'b0;
                  if (div_zero || overflow) begin
                     state        <= ST_DONE;
                     x_div_vld    <= 1'b1;
                     x_div_preg   <= idu_div_preg;
                     x_div_result <= special_res;
                  end else begin
                     state <= ST_CALC;
                     cnt   <= 6'd63;
                  end
               end
            end
            ST_CALC: begin
               if (cnt == '0) begin
                  state <= ST_FIX;
               end else begin
                  cnt <= cnt - 6'd1;
               end
            end
            ST_FIX: begin
               state        <= ST_DONE;
               x_div_vld    <= 1'b1;
               x_div_preg   <= preg_q;
               x_div_result <= op_is_rem(op_q) ? fixed_rem : fixed_quo;
            end
            ST_DONE: begin
               state         <= ST_IDLE;
               x_div_vld     <= 1'b0;
               div_idu_ready <= 1'b1;
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_exu_div.sv
// Self-checking bench for exu_div: a cycle-level behavioural model compared
// every cycle, plus directed vectors with hand-computed results and latencies.
module tb_exu_div;

   localparam logic [1:0]  DIV  = 2'b00;
   localparam logic [1:0]  DIVU = 2'b01;
   localparam logic [1:0]  REM  = 2'b10;
   localparam logic [1:0]  REMU = 2'b11;
   localparam logic [63:0] MINN = 64'h8000_0000_0000_0000;
   localparam logic [63:0] ONES = 64'hFFFF_FFFF_FFFF_FFFF;

   logic        clk = 1'b0;
   logic        rst_clk;
   logic        rtu_global_flush;
   logic        idu_div_sel;
   logic [1:0]  idu_div_op;
   logic [5:0]  idu_div_preg;
   logic [63:0] idu_div_src0;
   logic [63:0] idu_div_src1;
   logic        div_idu_ready;
   logic        x_div_vld;
   logic [5:0]  x_div_preg;
   logic [63:0] x_div_result;

   int n_checks = 0;
   int n_errors = 0;

   exu_div #(.PREG_W(6)) dut (
      .clk              (clk),
      .rst_clk          (rst_clk),
      .rtu_global_flush (rtu_global_flush),
      .idu_div_sel      (idu_div_sel),
      .idu_div_op       (idu_div_op),
      .idu_div_preg     (idu_div_preg),
      .idu_div_src0     (idu_div_src0),
      .idu_div_src1     (idu_div_src1),
      .div_idu_ready    (div_idu_ready),
      .x_div_vld        (x_div_vld),
      .x_div_preg       (x_div_preg),
      .x_div_result     (x_div_result)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%016h expected 0x%016h", name, act, exp);
      end
   endtask

   // Architectural result of one divide, straight from the op definitions.
   function automatic logic [63:0] ref_div(input logic [1:0] op, input logic [63:0] a, input logic [63:0] b);
      longint sa;
      longint sb;
      logic   sgn;
      logic   rem;
      sgn = (op == DIV) || (op == REM);
      rem = (op == REM) || (op == REMU);
      sa  = a;
      sb  = b;
      if (b == 64'd0) return rem ? a : ONES;
      if (sgn && a == MINN && b == ONES) return rem ? 64'd0 : a;
      if (sgn) return rem ? 64'(sa % sb) : 64'(sa / sb);
      return rem ? a % b : a / b;
   endfunction

   // Cycles from accept edge to the writeback cycle.
   function automatic int ref_lat(input logic [1:0] op, input logic [63:0] a, input logic [63:0] b);
      logic sgn;
      sgn = (op == DIV) || (op == REM);
      if (b == 64'd0 || (sgn && a == MINN && b == ONES)) return 1;
      return 66;
   endfunction

   // Model: one op in flight, due at a known cycle index; flush and reset drop it.
   logic        m_busy = 1'b0;
   int          m_cyc  = 0;
   int          m_due  = 0;
   logic [5:0]  m_preg = '0;
   logic [63:0] m_res  = '0;

   always @(posedge clk or negedge rst_clk) begin
      if (!rst_clk) begin
         m_busy <= 1'b0;
      end else begin
         if (rtu_global_flush) begin
            m_busy <= 1'b0;
         end else if (m_busy) begin
            if (m_cyc == m_due) m_busy <= 1'b0;
         end else if (idu_div_sel) begin
            m_busy <= 1'b1;
            m_due  <= m_cyc + ref_lat(idu_div_op, idu_div_src0, idu_div_src1);
            m_preg <= idu_div_preg;
            m_res  <= ref_div(idu_div_op, idu_div_src0, idu_div_src1);
         end
         m_cyc <= m_cyc + 1;
      end
   end

   // Compare DUT outputs against the model on every falling edge.
   always @(negedge clk) begin
      if (!rst_clk) begin
         check("cmp_rst_ready", div_idu_ready, 1);
         check("cmp_rst_vld", x_div_vld, 0);
         check("cmp_rst_preg", x_div_preg, 0);
         check("cmp_rst_result", x_div_result, 0);
      end else begin
         check("cmp_ready", div_idu_ready, !m_busy);
         check("cmp_vld", x_div_vld, m_busy && (m_cyc == m_due));
         if (m_busy && (m_cyc == m_due)) begin
            check("cmp_preg", x_div_preg, m_preg);
            check("cmp_result", x_div_result, m_res);
         end
      end
   end

   task automatic drive_issue(input logic [1:0] op, input logic [63:0] a, input logic [63:0] b, input logic [5:0] preg);
      idu_div_sel  = 1'b1;
      idu_div_op   = op;
      idu_div_src0 = a;
      idu_div_src1 = b;
      idu_div_preg = preg;
   endtask

   // Called at the falling edge of cycle k0 after accept; waits for writeback.
   task automatic wait_vld(input string name, input int k0, input int exp_lat, input logic [63:0] exp_res, input logic [5:0] exp_preg);
      int k;
      int ready_hi;
      k        = k0;
      ready_hi = int'(div_idu_ready);
      while (!x_div_vld && k < 200) begin
         @(negedge clk);
         k++;
         ready_hi += int'(div_idu_ready);
      end
      check({name, "_vld"}, x_div_vld, 1);
      check({name, "_lat"}, 64'(k), 64'(exp_lat));
      check({name, "_res"}, x_div_result, exp_res);
      check({name, "_preg"}, x_div_preg, exp_preg);
      check({name, "_busy_ready"}, 64'(ready_hi), 0);
   endtask

   // Issue after one idle cycle; returns at the falling edge of the DONE cycle.
   task automatic do_op(input string name, input logic [1:0] op, input logic [63:0] a, input logic [63:0] b, input logic [5:0] preg, input logic [63:0] exp_res, input int exp_lat);
      @(negedge clk);
      drive_issue(op, a, b, preg);
      @(posedge clk);
      @(negedge clk);
      idu_div_sel = 1'b0;
      wait_vld(name, 1, exp_lat, exp_res, preg);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1, "watchdog");
   end

   initial begin
      logic vld_seen;
      rst_clk          = 1'b0;
      rtu_global_flush = 1'b0;
      idu_div_sel      = 1'b0;
      idu_div_op       = DIV;
      idu_div_preg     = '0;
      idu_div_src0     = '0;
      idu_div_src1     = '0;

      // Model pins against hand-computed results.
      check("pin_div", ref_div(DIV, 64'd100, 64'd7), 64'd14);
      check("pin_div_neg", ref_div(DIV, 64'hFFFF_FFFF_FFFF_FF9C, 64'd7), 64'hFFFF_FFFF_FFFF_FFF2);
      check("pin_rem_neg", ref_div(REM, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2), ONES);
      check("pin_remu", ref_div(REMU, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2), 64'd1);
      check("pin_divu_z", ref_div(DIVU, 64'd5, 64'd0), ONES);
      check("pin_rem_z", ref_div(REM, 64'd5, 64'd0), 64'd5);
      check("pin_div_ovf", ref_div(DIV, MINN, ONES), MINN);
      check("pin_rem_ovf", ref_div(REM, MINN, ONES), 64'd0);
      check("pin_lat_norm", 64'(ref_lat(DIV, 64'd100, 64'd7)), 64'd66);
      check("pin_lat_ovf", 64'(ref_lat(DIV, MINN, ONES)), 64'd1);

      // Reset state.
      repeat (3) @(negedge clk);
      check("rst_ready", div_idu_ready, 1);
      check("rst_vld", x_div_vld, 0);
      check("rst_preg", x_div_preg, 0);
      check("rst_result", x_div_result, 0);
      #2 rst_clk = 1'b1;

      // Normal and special-case directed vectors.
      do_op("div_100_7", DIV, 64'd100, 64'd7, 6'h2A, 64'd14, 66);
      do_op("rem_m7_2", REM, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 6'h01, ONES, 66);
      do_op("remu_f9_2", REMU, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 6'h02, 64'd1, 66);
      do_op("div_m100_7", DIV, 64'hFFFF_FFFF_FFFF_FF9C, 64'd7, 6'h03, 64'hFFFF_FFFF_FFFF_FFF2, 66);
      do_op("div_100_m7", DIV, 64'd100, 64'hFFFF_FFFF_FFFF_FFF9, 6'h04, 64'hFFFF_FFFF_FFFF_FFF2, 66);
      do_op("rem_100_m7", REM, 64'd100, 64'hFFFF_FFFF_FFFF_FFF9, 6'h05, 64'd2, 66);
      do_op("divu_big", DIVU, ONES, 64'h1_0000_0000, 6'h06, 64'h0000_0000_FFFF_FFFF, 66);
      do_op("divu_5_0", DIVU, 64'd5, 64'd0, 6'h07, ONES, 1);
      do_op("rem_5_0", REM, 64'd5, 64'd0, 6'h08, 64'd5, 1);
      do_op("div_ovf", DIV, MINN, ONES, 6'h09, MINN, 1);
      do_op("rem_ovf", REM, MINN, ONES, 6'h0A, 64'd0, 1);
      do_op("divu_min_m1", DIVU, MINN, ONES, 6'h0B, 64'd0, 66);

      // Issue held through DONE: the DONE edge must not accept, the next one does.
      drive_issue(DIVU, 64'd100, 64'd10, 6'h0C);
      @(posedge clk);
      @(posedge clk);
      @(negedge clk);
      idu_div_sel = 1'b0;
      wait_vld("b2b", 1, 66, 64'd10, 6'h0C);

      // Issue coinciding with flush is dropped.
      @(negedge clk);
      drive_issue(DIV, 64'd9, 64'd3, 6'h0D);
      rtu_global_flush = 1'b1;
      @(negedge clk);
      idu_div_sel      = 1'b0;
      rtu_global_flush = 1'b0;
      check("flush_issue_dropped", div_idu_ready, 1);

      // Flush during CALC cycle 30 kills the op.
      drive_issue(DIV, 64'd1000, 64'd3, 6'h0E);
      @(posedge clk);
      @(negedge clk);
      idu_div_sel = 1'b0;
      repeat (29) @(negedge clk);
      rtu_global_flush = 1'b1;
      @(negedge clk);
      rtu_global_flush = 1'b0;
      check("flush_ready_next", div_idu_ready, 1);
      check("flush_vld_low", x_div_vld, 0);
      vld_seen = 1'b0;
      repeat (80) begin
         @(negedge clk);
         if (x_div_vld) vld_seen = 1'b1;
      end
      check("flush_no_vld", vld_seen, 0);
      do_op("divu_9_3", DIVU, 64'd9, 64'd3, 6'h0F, 64'd3, 66);

      // Issue held high while busy with changing operands: only the first counts.
      @(negedge clk);
      drive_issue(DIV, 64'd100, 64'd7, 6'h11);
      @(posedge clk);
      @(negedge clk);
      drive_issue(DIV, 64'd50, 64'd5, 6'h12);
      repeat (19) @(negedge clk);
      idu_div_sel = 1'b0;
      wait_vld("held_sel", 20, 66, 64'd14, 6'h11);

      // Reset pulsed mid-CALC: outputs clear immediately, no later writeback.
      @(negedge clk);
      drive_issue(DIVU, 64'd77, 64'd7, 6'h13);
      @(posedge clk);
      @(negedge clk);
      idu_div_sel = 1'b0;
      repeat (10) @(negedge clk);
      #2 rst_clk = 1'b0;
      #1;
      check("midrst_ready", div_idu_ready, 1);
      check("midrst_vld", x_div_vld, 0);
      check("midrst_preg", x_div_preg, 0);
      check("midrst_result", x_div_result, 0);
      @(negedge clk);
      #2 rst_clk = 1'b1;
      vld_seen = 1'b0;
      repeat (80) begin
         @(negedge clk);
         if (x_div_vld) vld_seen = 1'b1;
      end
      check("midrst_no_vld", vld_seen, 0);
      do_op("after_rst", DIVU, 64'd77, 64'd7, 6'h14, 64'd11, 66);

      repeat (3) @(negedge clk);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
